// File: rtl/s3g_resp_framer.sv
`default_nettype none
// ============================================================================
//  Module      : s3g_resp_framer
//  Description : Response framer. Collects payload bytes from the executor
//                into a buffer. On pl_send it transmits the frame
//                0xD5, LEN, payload[0..LEN-1], CRC8 to a UART transmitter,
//                one byte at a time, using a tx_wr / tx_done handshake.
//                The CRC is Dallas/Maxim CRC-8 (reflected poly 0x8C,
//                init 0x00, no final XOR) over the payload bytes only.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                pl_data/pl_wr  - payload byte and append strobe
//                pl_send        - close payload, start frame transmission
//                err_clr        - clear the sticky overflow flag
//                tx_data/tx_wr  - byte and write strobe to the UART
//                tx_done        - UART byte-complete pulse
//                busy           - frame in progress
//                overflow       - sticky: a payload byte was dropped
//                pkt_done       - 1-cycle pulse at the end of the frame
//  Revision    : 1.0 - initial release
// ============================================================================
module s3g_resp_framer #(
    parameter int MAX_LEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pl_data,
    input  logic       pl_wr,
    input  logic       pl_send,
    input  logic       err_clr,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_done,
    output logic       busy,
    output logic       overflow,
    output logic       pkt_done
);

    localparam int         c_AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] c_MAX_LEN = 8'(MAX_LEN);
    localparam logic [7:0] c_SYNC    = 8'hD5;

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_HDR  = 3'd1;
    localparam logic [2:0] c_LEN  = 3'd2;
    localparam logic [2:0] c_DATA = 3'd3;
    localparam logic [2:0] c_CRC  = 3'd4;
    localparam logic [2:0] c_WAIT = 3'd5;

    logic [2:0] state_q,    state_d;
    logic [2:0] resume_q,   resume_d;   // state entered when tx_done arrives in WAIT
    logic [7:0] count_q,    count_d;
    logic [7:0] idx_q,      idx_d;      // index of the next payload byte to issue
    logic [7:0] crc_q,      crc_d;
    logic [7:0] tx_data_q,  tx_data_d;
    logic       overflow_q, overflow_d;
    logic       pkt_done_q, pkt_done_d;

    logic [7:0] buf_q [MAX_LEN];
    logic       w_buf_we;
    logic       w_drop;
    logic [7:0] w_buf_rd;

    // One bit at a time, LSB first, reflected polynomial.
    function automatic logic [7:0] f_crc8(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ 8'h8C;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    assign w_buf_rd = buf_q[idx_q[c_AW-1:0]];

    // Payload storage has no reset: count_q alone defines what is valid.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            buf_q[count_q[c_AW-1:0]] <= pl_data;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_IDLE;
            resume_q   <= c_IDLE;
            count_q    <= 8'd0;
            idx_q      <= 8'd0;
            crc_q      <= 8'd0;
            tx_data_q  <= 8'd0;
            overflow_q <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            resume_q   <= resume_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            crc_q      <= crc_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // tx_data is registered and loaded on the edge that enters an issue
    // state, so tx_wr and the byte appear together and the byte then
    // stays put through WAIT until tx_done.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        resume_d   = resume_q;
        count_d    = count_q;
        idx_d      = idx_q;
        crc_d      = crc_q;
        tx_data_d  = tx_data_q;
        pkt_done_d = 1'b0;
        w_buf_we   = 1'b0;
        w_drop     = 1'b0;

        case (state_q)
            c_IDLE: begin
                if (pl_wr) begin
                    if (count_q < c_MAX_LEN) begin
                        w_buf_we = 1'b1;
                        count_d  = count_q + 8'd1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
                if (pl_send) begin
                    state_d   = c_HDR;
                    tx_data_d = c_SYNC;
                    crc_d     = 8'd0;
                    idx_d     = 8'd0;
                end
            end
            c_HDR: begin
                w_drop   = pl_wr;
                state_d  = c_WAIT;
                resume_d = c_LEN;
            end
            c_LEN: begin
                w_drop   = pl_wr;
                state_d  = c_WAIT;
                resume_d = (count_q == 8'd0) ? c_CRC : c_DATA;
            end
            c_DATA: begin
                // tx_data_q holds the payload byte being issued this cycle.
                w_drop   = pl_wr;
                crc_d    = f_crc8(crc_q, tx_data_q);
                idx_d    = idx_q + 8'd1;
                state_d  = c_WAIT;
                resume_d = ((idx_q + 8'd1) == count_q) ? c_CRC : c_DATA;
            end
            c_CRC: begin
                w_drop   = pl_wr;
                state_d  = c_WAIT;
                resume_d = c_IDLE;  // IDLE here marks end of frame
            end
            c_WAIT: begin
                w_drop = pl_wr;
                if (tx_done) begin
                    state_d = resume_q;
                    case (resume_q)
                        c_LEN:   tx_data_d = count_q;
                        c_DATA:  tx_data_d = w_buf_rd;
                        c_CRC:   tx_data_d = crc_q;
                        c_IDLE: begin
                            tx_data_d  = 8'd0;
                            count_d    = 8'd0;
                            pkt_done_d = 1'b1;
                        end
                        default: state_d = c_IDLE;
                    endcase
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

        // A drop in the same cycle as err_clr wins.
        overflow_d = (overflow_q & ~err_clr) | w_drop;
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        tx_wr    = 1'b0;
        busy     = 1'b0;
        tx_data  = tx_data_q;
        overflow = overflow_q;
        pkt_done = pkt_done_q;
        case (state_q)
            c_HDR, c_LEN, c_DATA, c_CRC: begin
                tx_wr = 1'b1;
                busy  = 1'b1;
            end
            c_WAIT: begin
                busy = 1'b1;
            end
            default: begin
                tx_wr = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_s3g_resp_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_s3g_resp_framer
//  Description : Self-checking bench for s3g_resp_framer. Unit 0 uses the
//                default MAX_LEN (32), unit 1 uses MAX_LEN=4. Expected frames
//                come from a queue-based model with an MSB-first CRC formula.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_s3g_resp_framer;

    typedef logic [7:0] bq_t [$];

    logic       clk;
    logic       rst;
    logic [7:0] pl_data  [2];
    logic       pl_wr    [2];
    logic       pl_send  [2];
    logic       err_clr  [2];
    logic       tx_done  [2];
    logic [7:0] tx_data  [2];
    logic       tx_wr    [2];
    logic       busy     [2];
    logic       overflow [2];
    logic       pkt_done [2];

    int n_tests;
    int n_fail;

    s3g_resp_framer u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .pl_data  (pl_data[0]),
        .pl_wr    (pl_wr[0]),
        .pl_send  (pl_send[0]),
        .err_clr  (err_clr[0]),
        .tx_data  (tx_data[0]),
        .tx_wr    (tx_wr[0]),
        .tx_done  (tx_done[0]),
        .busy     (busy[0]),
        .overflow (overflow[0]),
        .pkt_done (pkt_done[0])
    );

    s3g_resp_framer #(.MAX_LEN(4)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .pl_data  (pl_data[1]),
        .pl_wr    (pl_wr[1]),
        .pl_send  (pl_send[1]),
        .err_clr  (err_clr[1]),
        .tx_data  (tx_data[1]),
        .tx_wr    (tx_wr[1]),
        .tx_done  (tx_done[1]),
        .busy     (busy[1]),
        .overflow (overflow[1]),
        .pkt_done (pkt_done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] bitrev(input logic [7:0] b);
        logic [7:0] o;
        for (int i = 0; i < 8; i++) o[i] = b[7-i];
        return o;
    endfunction

    // Reflected CRC-8/MAXIM expressed as the plain MSB-first division by
    // x^8+x^5+x^4+1 (0x31) on bit-reversed bytes, result reversed.
    function automatic logic [7:0] ref_crc(input bq_t pl);
        logic [7:0] r;
        r = 8'h00;
        foreach (pl[j]) begin
            r = r ^ bitrev(pl[j]);
            for (int k = 0; k < 8; k++) begin
                r = r[7] ? ((r << 1) ^ 8'h31) : (r << 1);
            end
        end
        return bitrev(r);
    endfunction

    function automatic bq_t build_frame(input bq_t pl);
        bq_t f;
        f = {};
        f.push_back(8'hD5);
        f.push_back(8'(pl.size()));
        foreach (pl[j]) f.push_back(pl[j]);
        f.push_back(ref_crc(pl));
        return f;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic wr_byte(input int u, input logic [7:0] b);
        pl_data[u] = b;
        pl_wr[u]   = 1'b1;
        tick();
        pl_wr[u]   = 1'b0;
    endtask

    task automatic send(input int u);
        pl_send[u] = 1'b1;
        tick();
        pl_send[u] = 1'b0;
    endtask

    // Called right after the cycle in which pl_send was accepted. Acts as
    // the UART: each byte must be offered together with tx_wr, tx_wr must
    // drop after one cycle, tx_data must hold, and the next byte must come
    // in the cycle after tx_done. With noise set, pl_wr/pl_send are thrown
    // at the busy framer during the wait cycles.
    task automatic run_frame(input int u, input bq_t exp, input bit noise);
        int d;
        for (int k = 0; k < exp.size(); k++) begin
            chk_b("tx_wr_issue", tx_wr[u], 1'b1);
            chk_8("tx_data", tx_data[u], exp[k]);
            chk_b("busy_frame", busy[u], 1'b1);
            d = $urandom_range(1, 3);
            for (int c = 0; c < d; c++) begin
                if (noise) begin
                    pl_data[u] = 8'($urandom);
                    pl_wr[u]   = 1'b1;
                    pl_send[u] = 1'b1;
                end
                tick();
                pl_wr[u]   = 1'b0;
                pl_send[u] = 1'b0;
                chk_b("tx_wr_one_cycle", tx_wr[u], 1'b0);
                chk_8("tx_data_hold", tx_data[u], exp[k]);
                chk_b("pkt_done_early", pkt_done[u], 1'b0);
            end
            tx_done[u] = 1'b1;
            tick();
            tx_done[u] = 1'b0;
        end
        chk_b("pkt_done_pulse", pkt_done[u], 1'b1);
        chk_b("busy_end", busy[u], 1'b0);
        tick();
        chk_b("pkt_done_clear", pkt_done[u], 1'b0);
        chk_b("tx_wr_idle", tx_wr[u], 1'b0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bq_t pl;
        bit  ovf;
        bit  same;
        int  n;

        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        for (int u = 0; u < 2; u++) begin
            pl_data[u] = 8'h00;
            pl_wr[u]   = 1'b0;
            pl_send[u] = 1'b0;
            err_clr[u] = 1'b0;
            tx_done[u] = 1'b0;
        end
        repeat (3) tick();

        for (int u = 0; u < 2; u++) begin
            chk_b("rst_tx_wr", tx_wr[u], 1'b0);
            chk_8("rst_tx_data", tx_data[u], 8'h00);
            chk_b("rst_busy", busy[u], 1'b0);
            chk_b("rst_overflow", overflow[u], 1'b0);
            chk_b("rst_pkt_done", pkt_done[u], 1'b0);
        end
        rst = 1'b0;
        tick();

        // Seven-byte frame with known CRC 0x57.
        pl = '{8'h76, 8'h54, 8'h81, 8'hDA, 8'h03, 8'h00, 8'h00};
        foreach (pl[j]) wr_byte(0, pl[j]);
        send(0);
        run_frame(0, '{8'hD5, 8'h07, 8'h76, 8'h54, 8'h81, 8'hDA, 8'h03, 8'h00, 8'h00, 8'h57}, 1'b0);

        // pl_send together with the last pl_wr; known CRC 0xA0.
        wr_byte(0, 8'h76);
        wr_byte(0, 8'h54);
        pl_data[0] = 8'h81;
        pl_wr[0]   = 1'b1;
        pl_send[0] = 1'b1;
        tick();
        pl_wr[0]   = 1'b0;
        pl_send[0] = 1'b0;
        run_frame(0, '{8'hD5, 8'h03, 8'h76, 8'h54, 8'h81, 8'hA0}, 1'b0);

        // Empty payload: D5 00 00, busy spans exactly three tx_done pulses.
        send(0);
        run_frame(0, '{8'hD5, 8'h00, 8'h00}, 1'b0);

        // MAX_LEN=4 unit: six bytes, last two dropped.
        for (int b = 1; b <= 6; b++) wr_byte(1, 8'(b));
        chk_b("ovf_set_max4", overflow[1], 1'b1);
        // err_clr colliding with another drop keeps the flag.
        err_clr[1] = 1'b1;
        wr_byte(1, 8'h07);
        err_clr[1] = 1'b0;
        chk_b("ovf_clr_vs_drop", overflow[1], 1'b1);
        send(1);
        run_frame(1, build_frame('{8'h01, 8'h02, 8'h03, 8'h04}), 1'b0);
        chk_b("ovf_sticky", overflow[1], 1'b1);
        err_clr[1] = 1'b1;
        tick();
        err_clr[1] = 1'b0;
        chk_b("ovf_cleared", overflow[1], 1'b0);

        // pl_wr / pl_send while busy are ignored and flag overflow.
        wr_byte(0, 8'h11);
        wr_byte(0, 8'h22);
        send(0);
        run_frame(0, build_frame('{8'h11, 8'h22}), 1'b1);
        chk_b("ovf_busy_wr", overflow[0], 1'b1);
        // Spurious tx_done in IDLE.
        tx_done[0] = 1'b1;
        tick();
        tx_done[0] = 1'b0;
        chk_b("spurious_done_wr", tx_wr[0], 1'b0);
        chk_b("spurious_done_busy", busy[0], 1'b0);
        tick();
        chk_b("spurious_done_wr2", tx_wr[0], 1'b0);
        err_clr[0] = 1'b1;
        tick();
        err_clr[0] = 1'b0;
        chk_b("ovf_cleared0", overflow[0], 1'b0);
        // Nothing written during busy may have reached the buffer.
        send(0);
        run_frame(0, '{8'hD5, 8'h00, 8'h00}, 1'b0);

        // Reset after the LEN byte aborts the frame.
        wr_byte(0, 8'h31);
        wr_byte(0, 8'h32);
        wr_byte(0, 8'h33);
        send(0);
        chk_8("abort_hdr", tx_data[0], 8'hD5);
        tick();
        tx_done[0] = 1'b1;
        tick();
        tx_done[0] = 1'b0;
        chk_b("abort_len_wr", tx_wr[0], 1'b1);
        chk_8("abort_len", tx_data[0], 8'h03);
        tick();
        rst = 1'b1;
        tick();
        chk_b("abort_rst_wr", tx_wr[0], 1'b0);
        chk_b("abort_rst_busy", busy[0], 1'b0);
        chk_8("abort_rst_data", tx_data[0], 8'h00);
        rst = 1'b0;
        tx_done[0] = 1'b1;
        tick();
        tx_done[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_b("abort_quiet_wr", tx_wr[0], 1'b0);
            chk_b("abort_quiet_busy", busy[0], 1'b0);
            tick();
        end
        wr_byte(0, 8'hAA);
        send(0);
        run_frame(0, build_frame('{8'hAA}), 1'b0);

        // Random frames, including overflowing lengths and same-cycle send.
        for (int it = 0; it < 10; it++) begin
            pl   = {};
            ovf  = 1'b0;
            n    = $urandom_range(0, 40);
            same = 1'($urandom_range(0, 1));
            for (int j = 0; j < n; j++) begin
                pl_data[0] = 8'($urandom);
                pl_wr[0]   = 1'b1;
                if (same && j == n - 1) pl_send[0] = 1'b1;
                if (pl.size() < 32) pl.push_back(pl_data[0]);
                else ovf = 1'b1;
                tick();
                pl_wr[0] = 1'b0;
            end
            if (!(same && n > 0)) begin
                pl_send[0] = 1'b1;
                tick();
            end
            pl_send[0] = 1'b0;
            chk_b("rnd_overflow", overflow[0], ovf);
            run_frame(0, build_frame(pl), 1'b0);
            err_clr[0] = 1'b1;
            tick();
            err_clr[0] = 1'b0;
            chk_b("rnd_ovf_clear", overflow[0], 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/s3g_resp_framer.md
S3G_RESP_FRAMER -- requirements
Module: s3g_resp_framer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 32, giving the maximum payload bytes per frame (range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port pl_data  input  8  payload byte from the executor.
REQ-005 SHALL have port pl_wr  input  1  1-cycle strobe that appends pl_data to the payload buffer.
REQ-006 SHALL have port pl_send  input  1  1-cycle strobe that closes the payload and starts frame transmission.
REQ-007 SHALL have port err_clr  input  1  clears the overflow flag.
REQ-008 SHALL have port tx_data  output  8  byte presented to uart_transceiver.
REQ-009 SHALL have port tx_wr  output  1  1-cycle write strobe to uart_transceiver.
REQ-010 SHALL have port tx_done  input  1  1-cycle completion pulse from uart_transceiver.
REQ-011 SHALL have port busy  output  1  high from pl_send acceptance until frame end.
REQ-012 SHALL have port overflow  output  1  sticky flag: a payload byte was dropped.
REQ-013 SHALL have port pkt_done  output  1  1-cycle pulse when the last frame byte completes.

Function
REQ-014 SHALL transmit each frame as: 0xD5, LEN, LEN payload bytes in write order, CRC.
REQ-015 SHALL compute CRC as Dallas/Maxim CRC-8 (reflected polynomial 0x8C, initial value 0x00, no final XOR) over the payload bytes only.
REQ-016 SHALL store payload bytes in an internal MAX_LEN-deep buffer and track the count in an 8-bit counter.
REQ-017 SHALL use states IDLE, HDR, LEN, DATA, CRC, WAIT, with WAIT recording which state to resume.
REQ-018 SHALL, in IDLE, append a byte on pl_wr when count<MAX_LEN; when count==MAX_LEN it SHALL drop the byte and set overflow.
REQ-019 SHALL, on pl_wr and pl_send in the same IDLE cycle, append the byte first and then include it in the frame.
REQ-020 SHALL, on pl_send in IDLE, set busy in the next cycle and assert tx_wr with tx_data=0xD5 in that same next cycle.
REQ-021 SHALL, after every tx_wr, enter WAIT and issue the next byte's tx_wr in the cycle after tx_done is seen.
REQ-022 SHALL hold tx_wr high for exactly one cycle per byte and hold tx_data stable until tx_done.
REQ-023 SHALL, when LEN=0, go directly from LEN to CRC and send 0x00 as CRC.
REQ-024 SHALL reset the CRC to 0x00 at pl_send acceptance and update it once per payload byte as that byte is issued.
REQ-025 SHALL, on tx_done for the CRC byte, pulse pkt_done for one cycle, clear busy and count in the same cycle, and return to IDLE.
REQ-026 SHALL ignore pl_wr while busy and set overflow; it SHALL ignore pl_send while busy.
REQ-027 SHALL ignore tx_done outside WAIT.
REQ-028 SHALL clear overflow on err_clr; if err_clr and a drop occur in the same cycle, overflow SHALL end up set.
REQ-029 SHALL not stall the payload write path: one byte per cycle is accepted in IDLE.

Reset
REQ-030 SHALL, while rst is high, drive tx_wr=0, tx_data=0x00, busy=0, overflow=0, pkt_done=0, count=0, CRC=0x00 and state IDLE.
REQ-031 SHALL, on reset mid-frame, abort the frame: no further tx_wr, buffer contents discarded, next frame starts clean.

Verification
REQ-032 SHALL verify: write 76 54 81 DA 03 00 00, pl_send -> tx bytes D5 07 76 54 81 DA 03 00 00 57, then one pkt_done pulse.
REQ-033 SHALL verify: write 76 54 81 with pl_send on the same cycle as the last pl_wr -> tx bytes D5 03 76 54 81 A0.
REQ-034 SHALL verify: pl_send with an empty buffer -> tx bytes D5 00 00; busy spans exactly 3 tx_done pulses.
REQ-035 SHALL verify: MAX_LEN=4 with 6 bytes 01..06 written -> overflow=1, frame D5 04 01 02 03 04 plus CRC; err_clr then clears overflow.
REQ-036 SHALL verify: pl_wr/pl_send during busy -> ignored and overflow=1; a spurious tx_done in IDLE -> no tx_wr.
REQ-037 SHALL verify: rst asserted after the LEN byte -> tx_wr stays 0 and busy=0; a following 1-byte frame AA -> D5 01 AA with correct CRC.
